// File: rtl/csr_unit_if.sv
// csr_unit_if: execute-stage CSR access, retire/trap inputs and CSR status outputs of csr_unit
interface csr_unit_if #(
  parameter int REG_WIDTH = 64,
  parameter int CSR = 12
);
  logic [CSR-1:0] addr;
  logic [REG_WIDTH-1:0] val;
  logic valid;
  logic is_csr;
  logic csr_rw;
  logic csr_rs;
  logic csr_rc;
  logic wr_suppress;
  logic [1:0] priv;
  logic instr_retire;
  logic trap_valid;
  logic [REG_WIDTH-1:0] trap_cause;
  logic [REG_WIDTH-1:0] trap_pc;
  logic [REG_WIDTH-1:0] trap_tval;
  logic [REG_WIDTH-1:0] csr_result;
  logic csr_illegal;
  logic [REG_WIDTH-1:0] mtvec_out;
  logic [REG_WIDTH-1:0] mepc_out;
  modport master (
    output addr, val, valid, is_csr, csr_rw, csr_rs, csr_rc, wr_suppress, priv,
    output instr_retire, trap_valid, trap_cause, trap_pc, trap_tval,
    input csr_result, csr_illegal, mtvec_out, mepc_out
  );
  modport slave (
    input addr, val, valid, is_csr, csr_rw, csr_rs, csr_rc, wr_suppress, priv,
    input instr_retire, trap_valid, trap_cause, trap_pc, trap_tval,
    output csr_result, csr_illegal, mtvec_out, mepc_out
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: sparse machine-mode CSR file with masks, privilege/RO checks, trap capture; CSR_COUNTERS_EN adds mcycle/minstret
module csr_unit #(
  parameter int REG_WIDTH = 64,
  parameter int CSR = 12,
  parameter logic [REG_WIDTH-1:0] HART_ID = '0,
  parameter logic [REG_WIDTH-1:0] MTVEC_RESET = '0,
  parameter logic [63:0] MSTATUS_WMASK = 64'h0000_1888
) (
  input logic clk,
  input logic reset,
  csr_unit_if.slave bus
);
  typedef logic [REG_WIDTH-1:0] word_t;
  localparam bit RV32 = REG_WIDTH == 32;
  localparam word_t MS_MASK = word_t'(MSTATUS_WMASK);
  localparam word_t EPC_MASK = ~word_t'(3);
  localparam word_t TVEC_MASK = ~word_t'(2);
  word_t mstatus_q, mstatus_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  word_t mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] cyc_q, cyc_d, ins_q, ins_d, w64;
`endif
  logic [CSR-1:0] a;
  logic impl, access, wr_try, illegal, wr_en;
  word_t old, wdata;
  assign a = bus.addr;
  assign access = bus.valid & bus.is_csr;
  assign wr_try = bus.csr_rw | ((bus.csr_rs | bus.csr_rc) & ~bus.wr_suppress);
  assign illegal = access & (~impl | (bus.priv < a[9:8]) | (&a[11:10] & wr_try));
  assign wr_en = access & ~illegal & wr_try;
  assign wdata = bus.csr_rw ? bus.val : bus.csr_rs ? (old | bus.val) : (old & ~bus.val);
  assign bus.csr_result = illegal ? '0 : old;
  assign bus.csr_illegal = illegal;
  assign bus.mtvec_out = mtvec_q;
  assign bus.mepc_out = mepc_q;
`ifdef CSR_COUNTERS_EN
  assign w64 = 64'(wdata);
`endif
  // Address decode: current value of the addressed CSR and whether it exists
  always_comb begin
    impl = 1'b1;
    old = '0;
    case (a)
      12'h300: old = mstatus_q;
      12'h305: old = mtvec_q;
      12'h340: old = mscratch_q;
      12'h341: old = mepc_q;
      12'h342: old = mcause_q;
      12'h343: old = mtval_q;
      12'hF14: old = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00, 12'hC01: old = word_t'(cyc_q);
      12'hB02, 12'hC02: old = word_t'(ins_q);
      12'hB80, 12'hC80, 12'hC81: begin
        old = RV32 ? word_t'(cyc_q[63:32]) : '0;
        impl = RV32;
      end
      12'hB82, 12'hC82: begin
        old = RV32 ? word_t'(ins_q[63:32]) : '0;
        impl = RV32;
      end
`endif
      default: impl = 1'b0;
    endcase
  end
  // Next state: masked CSR writes, traps override the three trap CSRs, counter writes beat increments
  always_comb begin
    mstatus_d = (wr_en && a == 12'h300) ? (wdata & MS_MASK) : mstatus_q;
    mtvec_d = (wr_en && a == 12'h305) ? (wdata & TVEC_MASK) : mtvec_q;
    mscratch_d = (wr_en && a == 12'h340) ? wdata : mscratch_q;
    mepc_d = bus.trap_valid ? (bus.trap_pc & EPC_MASK) : (wr_en && a == 12'h341) ? (wdata & EPC_MASK) : mepc_q;
    mcause_d = bus.trap_valid ? bus.trap_cause : (wr_en && a == 12'h342) ? wdata : mcause_q;
    mtval_d = bus.trap_valid ? bus.trap_tval : (wr_en && a == 12'h343) ? wdata : mtval_q;
`ifdef CSR_COUNTERS_EN
    cyc_d = (wr_en && a == 12'hB00) ? (RV32 ? {cyc_q[63:32], w64[31:0]} : w64) :
            (wr_en && a == 12'hB80) ? {w64[31:0], cyc_q[31:0]} : cyc_q + 64'd1;
    ins_d = (wr_en && a == 12'hB02) ? (RV32 ? {ins_q[63:32], w64[31:0]} : w64) :
            (wr_en && a == 12'hB82) ? {w64[31:0], ins_q[31:0]} : ins_q + {63'd0, bus.instr_retire};
`endif
  end
  // State registers; reset beats every write, trap and increment
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_q <= '0;
      mtvec_q <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
`ifdef CSR_COUNTERS_EN
      cyc_q <= '0;
      ins_q <= '0;
`endif
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
`ifdef CSR_COUNTERS_EN
      cyc_q <= cyc_d;
      ins_q <= ins_d;
`endif
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit against a behavioural CSR model
module tb_csr_unit;
  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0100;
  localparam logic [63:0] HART = 64'd5;
  localparam logic [63:0] MSW = 64'h0000_1888;
  localparam logic [2:0] RW = 3'b100, RS = 3'b010, RC = 3'b001;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cyc, m_ins;
  logic [11:0] addrs [0:16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14,
                                12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02, 12'hB80, 12'h7C0,
                                12'h000, 12'h301, 12'hF11};
  csr_unit_if #(.REG_WIDTH(64), .CSR(12)) bus ();
  csr_unit #(.REG_WIDTH(64), .CSR(12), .HART_ID(HART), .MTVEC_RESET(MTVEC_RST), .MSTATUS_WMASK(MSW))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14: return 1'b1;
      12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02: return CNT;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [63:0] m_old(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hF14: return HART;
      12'hB00, 12'hC00, 12'hC01: return CNT ? m_cyc : 64'd0;
      12'hB02, 12'hC02: return CNT ? m_ins : 64'd0;
      default: return 64'd0;
    endcase
  endfunction
  function automatic bit m_wrtry();
    return bus.csr_rw | ((bus.csr_rs | bus.csr_rc) & ~bus.wr_suppress);
  endfunction
  function automatic bit m_ill();
    if (!(bus.valid && bus.is_csr)) return 1'b0;
    return !m_impl(bus.addr) || (bus.priv < bus.addr[9:8]) || (bus.addr[11:10] == 2'b11 && m_wrtry());
  endfunction
  task automatic m_update();
    logic [63:0] old, nv;
    bit wr;
    if (reset) begin
      m_mstatus = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    old = m_old(bus.addr);
    nv = bus.csr_rw ? bus.val : bus.csr_rs ? (old | bus.val) : (old & ~bus.val);
    wr = bus.valid && bus.is_csr && !m_ill() && m_wrtry();
    m_cyc = m_cyc + 1;
    if (bus.instr_retire) m_ins = m_ins + 1;
    if (wr)
      case (bus.addr)
        12'h300: m_mstatus = nv & MSW;
        12'h305: m_mtvec = nv & ~64'd2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~64'd3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: m_cyc = nv;
        12'hB02: m_ins = nv;
        default: ;
      endcase
    if (bus.trap_valid) begin
      m_mepc = bus.trap_pc & ~64'd3;
      m_mcause = bus.trap_cause;
      m_mtval = bus.trap_tval;
    end
  endtask
  task automatic idle();
    bus.valid = 0; bus.is_csr = 0; bus.addr = '0; bus.val = '0;
    {bus.csr_rw, bus.csr_rs, bus.csr_rc} = 3'b000; bus.wr_suppress = 0; bus.priv = 2'd3;
    bus.instr_retire = 0; bus.trap_valid = 0; bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
    #1;
  endtask
  task automatic op(input logic [11:0] a, input logic [63:0] v, input logic [2:0] ops, input bit sup, input logic [1:0] p);
    bus.valid = 1; bus.is_csr = 1; bus.addr = a; bus.val = v;
    {bus.csr_rw, bus.csr_rs, bus.csr_rc} = ops; bus.wr_suppress = sup; bus.priv = p;
    bus.instr_retire = 0; bus.trap_valid = 0;
    #1;
  endtask
  task automatic rd(input logic [11:0] a, input logic [1:0] p);
    op(a, 64'd0, RS, 1'b1, p);
  endtask
  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1; idle(); tick(); tick(); reset = 0; #1;
    checks++; if (bus.mtvec_out !== MTVEC_RST) begin errors++; $display("FAIL rst_mtvec_out: got %h expected %h", bus.mtvec_out, MTVEC_RST); end
    checks++; if (bus.mepc_out !== 64'd0) begin errors++; $display("FAIL rst_mepc_out: got %h expected 0", bus.mepc_out); end
    rd(12'h305, 3);
    checks++; if (bus.csr_result !== MTVEC_RST) begin errors++; $display("FAIL rst_read_mtvec: got %h expected %h", bus.csr_result, MTVEC_RST); end
    rd(12'hF14, 3);
    checks++; if (bus.csr_result !== HART) begin errors++; $display("FAIL read_mhartid: got %h expected %h", bus.csr_result, HART); end
    rd(12'h7C0, 3);
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl_illegal: got %b expected 1", bus.csr_illegal); end
    checks++; if (bus.csr_result !== 64'd0) begin errors++; $display("FAIL unimpl_result: got %h expected 0", bus.csr_result); end
  endtask
  task automatic test_scratch();
    op(12'h340, 64'hDEAD, RW, 0, 3); tick();
    op(12'h340, 64'hF0000, RS, 0, 3);
    checks++; if (bus.csr_result !== 64'hDEAD) begin errors++; $display("FAIL rs_old_value: got %h expected DEAD", bus.csr_result); end
    tick();
    rd(12'h340, 3);
    checks++; if (bus.csr_result !== 64'hFDEAD) begin errors++; $display("FAIL rs_new_value: got %h expected FDEAD", bus.csr_result); end
    tick();
    op(12'h340, 64'hAD, RC, 0, 3); tick();
    rd(12'h340, 3);
    checks++; if (bus.csr_result !== 64'hFDE00) begin errors++; $display("FAIL rc_value: got %h expected FDE00", bus.csr_result); end
    tick();
  endtask
  task automatic test_mstatus();
    op(12'h300, '1, RW, 0, 3); tick();
    rd(12'h300, 3);
    checks++; if (bus.csr_result !== MSW) begin errors++; $display("FAIL mstatus_mask: got %h expected %h", bus.csr_result, MSW); end
    rd(12'h300, 0);
    checks++; if (bus.csr_illegal !== 1'b1 || bus.csr_result !== 64'd0) begin errors++; $display("FAIL mstatus_upriv: got ill=%b res=%h expected ill=1 res=0", bus.csr_illegal, bus.csr_result); end
    op(12'h300, 64'd0, RW, 0, 0); tick();
    rd(12'h300, 3);
    checks++; if (bus.csr_result !== MSW) begin errors++; $display("FAIL mstatus_unchanged: got %h expected %h", bus.csr_result, MSW); end
    op(12'h305, 64'h1237, RW, 0, 3); tick(); idle();
    checks++; if (bus.mtvec_out !== 64'h1235) begin errors++; $display("FAIL mtvec_bit1: got %h expected 1235", bus.mtvec_out); end
  endtask
  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    op(12'hC00, 64'd5, RW, 0, 3);
    checks++; if (bus.csr_illegal !== 1'b1 || bus.csr_result !== 64'd0) begin errors++; $display("FAIL ro_write: got ill=%b res=%h expected ill=1 res=0", bus.csr_illegal, bus.csr_result); end
    rd(12'hC00, 0);
    checks++; if (bus.csr_illegal !== 1'b0 || bus.csr_result !== m_cyc) begin errors++; $display("FAIL cycle_read: got ill=%b res=%h expected ill=0 res=%h", bus.csr_illegal, bus.csr_result, m_cyc); end
    op(12'hB00, '1, RW, 0, 3); tick();
    rd(12'hB00, 3);
    checks++; if (bus.csr_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mcycle_write: got %h expected all ones", bus.csr_result); end
    tick(); rd(12'hC01, 3);
    checks++; if (bus.csr_result !== 64'd0) begin errors++; $display("FAIL mcycle_wrap: got %h expected 0", bus.csr_result); end
    op(12'hB02, 64'd5, RW, 0, 3); bus.instr_retire = 1; tick();
    rd(12'hC02, 0);
    checks++; if (bus.csr_result !== 64'd5) begin errors++; $display("FAIL minstret_write_wins: got %h expected 5", bus.csr_result); end
`else
    op(12'hC00, 64'd5, RW, 0, 3);
    checks++; if (bus.csr_illegal !== 1'b1 || bus.csr_result !== 64'd0) begin errors++; $display("FAIL nocnt_cycle_write: got ill=%b res=%h expected ill=1 res=0", bus.csr_illegal, bus.csr_result); end
    rd(12'hC00, 0);
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL nocnt_cycle_read: got ill=%b expected 1", bus.csr_illegal); end
    rd(12'hB02, 3);
    checks++; if (bus.csr_illegal !== 1'b1 || bus.csr_result !== 64'd0) begin errors++; $display("FAIL nocnt_minstret: got ill=%b res=%h expected ill=1 res=0", bus.csr_illegal, bus.csr_result); end
`endif
    rd(12'hB80, 3);
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL high_half_rv64: got ill=%b expected 1", bus.csr_illegal); end
    tick();
  endtask
  task automatic test_trap();
    op(12'h341, 64'h40, RW, 0, 3);
    bus.trap_valid = 1; bus.trap_pc = 64'h1003; bus.trap_cause = 64'd2; bus.trap_tval = 64'hBAD;
    tick(); idle();
    checks++; if (bus.mepc_out !== 64'h1000) begin errors++; $display("FAIL trap_mepc: got %h expected 1000", bus.mepc_out); end
    rd(12'h342, 3);
    checks++; if (bus.csr_result !== 64'd2) begin errors++; $display("FAIL trap_mcause: got %h expected 2", bus.csr_result); end
    rd(12'h343, 3);
    checks++; if (bus.csr_result !== 64'hBAD) begin errors++; $display("FAIL trap_mtval: got %h expected BAD", bus.csr_result); end
    op(12'h340, 64'h1234, RW, 0, 3);
    bus.trap_valid = 1; bus.trap_pc = 64'h2002; bus.trap_cause = 64'd7; bus.trap_tval = 64'd9;
    tick();
    rd(12'h340, 3);
    checks++; if (bus.csr_result !== 64'h1234 || bus.mepc_out !== 64'h2000) begin errors++; $display("FAIL trap_other_write: got scratch=%h mepc=%h expected 1234/2000", bus.csr_result, bus.mepc_out); end
    tick();
  endtask
  task automatic test_random();
    logic exp_ill;
    logic [63:0] exp_res;
    for (int i = 0; i < 400; i++) begin
      bus.valid = $urandom_range(0, 9) != 0;
      bus.is_csr = $urandom_range(0, 9) != 0;
      bus.addr = addrs[$urandom_range(0, 16)];
      bus.val = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      {bus.csr_rw, bus.csr_rs, bus.csr_rc} = 3'($urandom_range(0, 7));
      bus.wr_suppress = 1'($urandom_range(0, 1));
      bus.priv = 2'($urandom_range(0, 3));
      bus.instr_retire = 1'($urandom_range(0, 1));
      bus.trap_valid = $urandom_range(0, 9) == 0;
      bus.trap_cause = 64'($urandom);
      bus.trap_pc = {$urandom, $urandom};
      bus.trap_tval = {$urandom, $urandom};
      #1;
      exp_ill = m_ill();
      exp_res = exp_ill ? 64'd0 : m_old(bus.addr);
      checks++; if (bus.csr_illegal !== exp_ill) begin errors++; $display("FAIL rand_illegal[%0d] addr=%h: got %b expected %b", i, bus.addr, bus.csr_illegal, exp_ill); end
      checks++; if (bus.csr_result !== exp_res) begin errors++; $display("FAIL rand_result[%0d] addr=%h: got %h expected %h", i, bus.addr, bus.csr_result, exp_res); end
      checks++; if (bus.mtvec_out !== m_mtvec || bus.mepc_out !== m_mepc) begin errors++; $display("FAIL rand_outs[%0d]: got mtvec=%h mepc=%h expected %h/%h", i, bus.mtvec_out, bus.mepc_out, m_mtvec, m_mepc); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_scratch();
    test_mstatus();
    test_counters();
    test_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
